// File: rtl/aes_key_sched_ctrl.sv
// Command sequencer in front of a shared-key AES encrypt/decrypt core.
// Jobs carry their own key; a key change drains both core pipelines,
// strobes the new key into the core and waits for the expanded key
// before any further job is issued, so data never sees a key change.
module aes_key_sched_ctrl #(
    parameter int MAX_INFLIGHT = 32,
    parameter int KEY_TIMEOUT  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_op,
    input  logic [127:0]                    cmd_data,
    input  logic [127:0]                    cmd_key,
    input  logic                            key_flush,
    input  logic                            clear_err,
    output logic                            load_new_key,
    output logic [127:0]                    cipher_key,
    input  logic                            key_is_valid,
    output logic                            enc_in_valid,
    output logic                            dec_in_valid,
    output logic [127:0]                    plain_text,
    output logic [127:0]                    cipher_text_in,
    input  logic                            enc_out_valid,
    input  logic                            dec_out_valid,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            busy,
    output logic                            key_err,
    output logic                            cnt_err
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam int TW = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;

    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_WAIT_KEY = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;

    logic [2:0]    state_r;
    logic [127:0]  cur_key_r;
    logic          key_loaded_r;
    logic [CW-1:0] inflight_r;
    logic [TW-1:0] timer_r;
    logic          key_err_r;
    logic          cnt_err_r;
    logic          load_r;
    logic          enc_iv_r;
    logic          dec_iv_r;
    logic [127:0]  pt_r;
    logic [127:0]  ct_r;

    logic          key_match_s;
    logic          cmd_ready_s;
    logic          issue_hs_s;
    logic          issue_pending_s;
    logic [CW:0]   up_s;
    logic [CW:0]   dn_s;
    logic [CW:0]   diff_s;
    logic [CW-1:0] inflight_nxt_s;
    logic          cnt_uf_s;

    // Acceptance: only in RUN, only for the loaded key, only with pipeline room
    always_comb begin
        key_match_s     = key_loaded_r && (cmd_key == cur_key_r);
        issue_pending_s = enc_iv_r || dec_iv_r;
        if (state_r == ST_RUN) begin
            cmd_ready_s = cmd_valid && key_match_s && (inflight_r < CW'(MAX_INFLIGHT));
        end else begin
            cmd_ready_s = 1'b0;
        end
        issue_hs_s = cmd_valid && cmd_ready_s;
    end

    // Outstanding-op arithmetic: one increment and up to two decrements per cycle, clamped at zero
    always_comb begin
        up_s   = {1'b0, inflight_r} + {{CW{1'b0}}, issue_hs_s};
        dn_s   = {{CW{1'b0}}, enc_out_valid} + {{CW{1'b0}}, dec_out_valid};
        diff_s = up_s - dn_s;
        if (dn_s > up_s) begin
            cnt_uf_s       = 1'b1;
            inflight_nxt_s = {CW{1'b0}};
        end else begin
            cnt_uf_s       = 1'b0;
            inflight_nxt_s = diff_s[CW-1:0];
        end
    end

    // Outstanding-op counter and its sticky underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= {CW{1'b0}};
            cnt_err_r  <= 1'b0;
        end else begin
            inflight_r <= inflight_nxt_s;
            if (cnt_uf_s) begin
                cnt_err_r <= 1'b1;
            end else if (clear_err) begin
                cnt_err_r <= 1'b0;
            end
        end
    end

    // Key sequencing FSM: drain, load, wait for expansion, or time out into ERROR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            cur_key_r    <= 128'd0;
            key_loaded_r <= 1'b0;
            timer_r      <= {TW{1'b0}};
            key_err_r    <= 1'b0;
            load_r       <= 1'b0;
        end else begin
            load_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (key_flush) begin
                        key_loaded_r <= 1'b0;
                    end
                    if (cmd_valid && !key_match_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (key_flush) begin
                        key_loaded_r <= 1'b0;
                    end
                    // the last issue strobe is still on its way to the core
                    if ((inflight_r == {CW{1'b0}}) && !issue_pending_s) begin
                        if (cmd_valid) begin
                            cur_key_r <= cmd_key;
                            load_r    <= 1'b1;
                            state_r   <= ST_LOAD;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_LOAD: begin
                    key_loaded_r <= 1'b0;
                    timer_r      <= {TW{1'b0}};
                    state_r      <= ST_WAIT_KEY;
                end
                ST_WAIT_KEY: begin
                    // a flush here is ignored: the load in progress is the fresh key
                    if (key_is_valid) begin
                        key_loaded_r <= 1'b1;
                        state_r      <= ST_RUN;
                    end else if (timer_r == TW'(KEY_TIMEOUT - 1)) begin
                        key_err_r <= 1'b1;
                        state_r   <= ST_ERROR;
                    end else begin
                        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                ST_ERROR: begin
                    if (key_flush) begin
                        key_loaded_r <= 1'b0;
                    end
                    if (clear_err) begin
                        key_err_r    <= 1'b0;
                        key_loaded_r <= 1'b0;
                        state_r      <= ST_RUN;
                    end
                end
                default: begin
                    key_loaded_r <= 1'b0;
                    state_r      <= ST_RUN;
                end
            endcase
        end
    end

    // Issue stage: one-cycle strobe per handshake; the unused data path keeps its value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_iv_r <= 1'b0;
            dec_iv_r <= 1'b0;
            pt_r     <= 128'd0;
            ct_r     <= 128'd0;
        end else begin
            enc_iv_r <= issue_hs_s && !cmd_op;
            dec_iv_r <= issue_hs_s && cmd_op;
            if (issue_hs_s && !cmd_op) begin
                pt_r <= cmd_data;
            end
            if (issue_hs_s && cmd_op) begin
                ct_r <= cmd_data;
            end
        end
    end

    assign cmd_ready      = cmd_ready_s;
    assign load_new_key   = load_r;
    assign cipher_key     = cur_key_r;
    assign enc_in_valid   = enc_iv_r;
    assign dec_in_valid   = dec_iv_r;
    assign plain_text     = pt_r;
    assign cipher_text_in = ct_r;
    assign inflight       = inflight_r;
    assign busy           = (state_r != ST_RUN) || (inflight_r != {CW{1'b0}});
    assign key_err        = key_err_r;
    assign cnt_err        = cnt_err_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a small AES-core model:
// fixed-latency completion queues (holdable) and a key-valid delay.
module tb_aes_key_sched_ctrl;

    localparam int CORE_LAT = 11;
    localparam int KV_DLY   = 10;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K3 = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] D3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] D4 = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] DA = 128'haaaa0000000000000000000000000001;
    localparam logic [127:0] DB = 128'hbbbb0000000000000000000000000002;
    localparam logic [127:0] DC = 128'hcccc0000000000000000000000000003;
    localparam logic [127:0] DD = 128'hdddd0000000000000000000000000004;

    logic         clk, rst_n;
    logic         cmd_valid, cmd_ready, cmd_op;
    logic [127:0] cmd_data, cmd_key;
    logic         key_flush, clear_err, load_new_key;
    logic [127:0] cipher_key;
    logic         key_is_valid;
    logic         enc_in_valid, dec_in_valid;
    logic [127:0] plain_text, cipher_text_in;
    logic         enc_out_valid, dec_out_valid;
    logic [5:0]   inflight;
    logic         busy, key_err, cnt_err;

    int n_cmp;
    int n_fail;

    aes_key_sched_ctrl #(.MAX_INFLIGHT(32), .KEY_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_key(cmd_key),
        .key_flush(key_flush), .clear_err(clear_err),
        .load_new_key(load_new_key), .cipher_key(cipher_key), .key_is_valid(key_is_valid),
        .enc_in_valid(enc_in_valid), .dec_in_valid(dec_in_valid),
        .plain_text(plain_text), .cipher_text_in(cipher_text_in),
        .enc_out_valid(enc_out_valid), .dec_out_valid(dec_out_valid),
        .inflight(inflight), .busy(busy), .key_err(key_err), .cnt_err(cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: completions after CORE_LAT cycles, held back while core_run is low
    logic core_run, man_enc, man_dec, mdl_enc, mdl_dec;
    int   cyc;
    int   enc_q[$];
    int   dec_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            enc_q.delete();
            dec_q.delete();
            mdl_enc <= 1'b0;
            mdl_dec <= 1'b0;
        end else begin
            if (enc_in_valid === 1'b1) enc_q.push_back(cyc);
            if (dec_in_valid === 1'b1) dec_q.push_back(cyc);
            if (core_run && enc_q.size() > 0 && (cyc - enc_q[0]) >= CORE_LAT - 1) begin
                mdl_enc <= 1'b1;
                void'(enc_q.pop_front());
            end else begin
                mdl_enc <= 1'b0;
            end
            if (core_run && dec_q.size() > 0 && (cyc - dec_q[0]) >= CORE_LAT - 1) begin
                mdl_dec <= 1'b1;
                void'(dec_q.pop_front());
            end else begin
                mdl_dec <= 1'b0;
            end
        end
    end
    assign enc_out_valid = mdl_enc | man_enc;
    assign dec_out_valid = mdl_dec | man_dec;

    // Key-expansion model: key_is_valid drops on a load and rises KV_DLY cycles after it
    logic kv_r, kv_en;
    int   kv_cnt;
    always @(posedge clk) begin
        if (!rst_n) begin
            kv_r   <= 1'b0;
            kv_cnt <= 0;
        end else if (load_new_key === 1'b1) begin
            kv_r   <= 1'b0;
            kv_cnt <= KV_DLY - 1;
        end else if (kv_cnt != 0) begin
            kv_cnt <= kv_cnt - 1;
            if (kv_cnt == 1 && kv_en) kv_r <= 1'b1;
        end
    end
    assign key_is_valid = kv_r;

    // Event monitor: load pulses, issue strobes, inflight peak
    int load_cnt, issue_cnt, peak;
    always @(posedge clk) begin
        if (load_new_key === 1'b1) load_cnt <= load_cnt + 1;
        if (enc_in_valid === 1'b1 || dec_in_valid === 1'b1) issue_cnt <= issue_cnt + 1;
        if (rst_n === 1'b1 && int'(inflight) > peak) peak <= int'(inflight);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one job and hold it until accepted; returns one sample after the handshake edge
    task automatic send(input logic op, input logic [127:0] key, input logic [127:0] data, input int budget);
        bit got;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_data  = data;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (cmd_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (got) tick();
        cmd_valid = 1'b0;
        chk1("send_handshake", got, 1'b1);
    endtask

    task automatic wait_load(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (load_new_key === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk1("load_seen", got, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (inflight === 6'd0 && busy === 1'b0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk1("idle_reached", got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  base_issue;
        int  base_load;
        int  n;
        bit  got;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = 128'd0; cmd_key = 128'd0;
        key_flush = 1'b0; clear_err = 1'b0; core_run = 1'b1; kv_en = 1'b1;
        man_enc = 1'b0; man_dec = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // reset state
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk_int("rst_inflight", int'(inflight), 0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_load", load_new_key, 1'b0);
        chk1("rst_enc_iv", enc_in_valid, 1'b0);
        chk128("rst_plain", plain_text, 128'd0);
        chk128("rst_cipher_key", cipher_key, 128'd0);
        chk1("rst_key_err", key_err, 1'b0);
        chk1("rst_cnt_err", cnt_err, 1'b0);

        // cold start: first job forces a load of K1
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = K1; cmd_data = D1;
        #1;
        chk1("cold_ready_low", cmd_ready, 1'b0);
        wait_load(10);
        chk128("cold_cipher_key", cipher_key, K1);
        n = 0;
        while (key_is_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        tick();
        chk1("cold_no_issue_kv_plus1", enc_in_valid, 1'b0);
        tick();
        chk1("cold_enc_kv_plus2", enc_in_valid, 1'b1);
        chk128("cold_plain", plain_text, D1);
        chk_int("cold_one_load", load_cnt, 1);
        chk_int("cold_inflight", int'(inflight), 1);
        cmd_valid = 1'b0;
        wait_idle(40);
        chk1("cold_cnt_err", cnt_err, 1'b0);

        // streaming: 40 jobs, completions held until the limit stalls acceptance
        core_run = 1'b0;
        for (int i = 0; i < 32; i++) send(1'b0, K1, 128'(i), 2);
        cmd_valid = 1'b1; cmd_key = K1; cmd_data = 128'd32;
        #1;
        chk1("stream_stall_at_max", cmd_ready, 1'b0);
        chk_int("stream_inflight_max", int'(inflight), 32);
        tick();
        chk1("stream_still_stalled", cmd_ready, 1'b0);
        core_run = 1'b1;
        for (int i = 32; i < 40; i++) send(1'b0, K1, 128'(i), 30);
        wait_idle(120);
        chk_int("stream_peak", peak, 32);
        chk1("stream_cnt_err", cnt_err, 1'b0);
        chk_int("stream_issue_count", issue_cnt, 41);

        // mixed enc/dec with a double completion in one cycle
        core_run = 1'b0;
        send(1'b0, K1, DA, 2);
        chk1("mix_enc_iv", enc_in_valid, 1'b1);
        chk128("mix_plain", plain_text, DA);
        send(1'b1, K1, DB, 2);
        chk1("mix_dec_iv", dec_in_valid, 1'b1);
        chk1("mix_enc_iv_low", enc_in_valid, 1'b0);
        chk128("mix_cipher_in", cipher_text_in, DB);
        chk128("mix_plain_held", plain_text, DA);
        send(1'b0, K1, DC, 2);
        send(1'b1, K1, DD, 2);
        chk_int("mix_inflight4", int'(inflight), 4);
        repeat (12) tick();
        core_run = 1'b1;
        tick();
        chk_int("mix_before_dec", int'(inflight), 4);
        tick();
        chk_int("mix_dec_by_2", int'(inflight), 2);
        tick();
        chk_int("mix_dec_to_0", int'(inflight), 0);
        chk1("mix_cnt_err", cnt_err, 1'b0);

        // key switch K1 -> K2 with five jobs in flight
        core_run = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, K1, 128'(100 + i), 2);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = K2; cmd_data = D2;
        #1;
        chk1("ks_ready_low", cmd_ready, 1'b0);
        tick();
        base_issue = issue_cnt;
        base_load  = load_cnt;
        repeat (4) tick();
        chk1("ks_no_load_while_busy", load_new_key, 1'b0);
        chk_int("ks_inflight_held", int'(inflight), 5);
        chk1("ks_busy", busy, 1'b1);
        chk_int("ks_load_cnt_held", load_cnt, base_load);
        core_run = 1'b1;
        wait_load(60);
        chk128("ks_cipher_key", cipher_key, K2);
        chk_int("ks_inflight_at_load", int'(inflight), 0);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (cmd_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk1("ks_ready_after_load", got, 1'b1);
        chk_int("ks_no_issue_in_switch", issue_cnt, base_issue);
        tick();
        cmd_valid = 1'b0;
        chk1("ks_enc_iv", enc_in_valid, 1'b1);
        chk128("ks_plain", plain_text, D2);
        wait_idle(60);

        // key expansion timeout
        kv_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_key = K3; cmd_data = D3;
        wait_load(10);
        repeat (64) tick();
        chk1("to_no_err_at_63", key_err, 1'b0);
        tick();
        chk1("to_key_err", key_err, 1'b1);
        chk1("to_ready_low", cmd_ready, 1'b0);
        chk1("to_busy", busy, 1'b1);
        repeat (5) tick();
        chk1("to_ready_held", cmd_ready, 1'b0);
        chk1("to_no_load", load_new_key, 1'b0);
        chk1("to_err_sticky", key_err, 1'b1);
        kv_en = 1'b1;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk1("to_err_cleared", key_err, 1'b0);
        wait_load(10);
        chk128("to_reload_key", cipher_key, K3);
        send(1'b1, K3, D3, 30);
        chk1("to_dec_iv", dec_in_valid, 1'b1);
        chk128("to_cipher_in", cipher_text_in, D3);
        wait_idle(40);

        // spurious completion with nothing in flight
        man_dec = 1'b1;
        tick();
        man_dec = 1'b0;
        chk1("uf_cnt_err", cnt_err, 1'b1);
        chk_int("uf_inflight_clamped", int'(inflight), 0);
        tick();
        chk1("uf_cnt_err_sticky", cnt_err, 1'b1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk1("uf_cnt_err_cleared", cnt_err, 1'b0);

        // flush forces a reload of the same key
        key_flush = 1'b1;
        tick();
        key_flush = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = K3; cmd_data = D4;
        #1;
        chk1("fl_ready_low", cmd_ready, 1'b0);
        base_load = load_cnt;
        wait_load(10);
        chk128("fl_reload_key", cipher_key, K3);
        send(1'b0, K3, D4, 30);
        chk1("fl_enc_iv", enc_in_valid, 1'b1);
        chk128("fl_plain", plain_text, D4);
        chk_int("fl_one_reload", load_cnt, base_load + 1);
        wait_idle(40);
        chk1("end_key_err", key_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Command sequencer in front of the shared-key AES encrypt/decrypt core. It accepts a single stream of enc/dec jobs, each carrying its own 128-bit key. It issues jobs into the core's pipelines and tracks in-flight operations. When a job's key differs from the loaded key, it drains both pipelines, reloads the key and waits for key validity, so the core never sees a key change with data in flight.

## Interface
- MAX_INFLIGHT, 32: max outstanding ops across both pipelines; power of 2, at least 2.
- KEY_TIMEOUT, 64: cycles allowed in WAIT_KEY before error.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  job offered.
- cmd_ready  out  1  job accepted when high with cmd_valid.
- cmd_op  in  1  0 = encrypt, 1 = decrypt.
- cmd_data  in  128  plaintext (enc) or ciphertext (dec).
- cmd_key  in  128  key for this job.
- key_flush  in  1  pulse; marks the loaded key invalid.
- clear_err  in  1  pulse; leaves ERROR.
- load_new_key  out  1  one-cycle key load strobe to the core.
- cipher_key  out  128  key to the core; stable outside LOAD transitions.
- key_is_valid  in  1  core key-valid status.
- enc_in_valid / dec_in_valid  out  1  issue strobes to the core.
- plain_text / cipher_text_in  out  128  issue data to the core.
- enc_out_valid / dec_out_valid  in  1  core completion strobes.
- inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding op count.
- busy  out  1  state is not RUN, or inflight is not 0.
- key_err  out  1  sticky key expansion timeout.
- cnt_err  out  1  sticky completion received with inflight = 0.

## Operation
- Registers:
  - state: RUN, DRAIN, LOAD, WAIT_KEY, ERROR.
  - cur_key[127:0].
  - key_loaded.
  - inflight.
  - timer.
- Reset values:
  - state = RUN, key_loaded = 0, cur_key = 0, inflight = 0, timer = 0.
  - All strobes, data outputs, key_err and cnt_err = 0.
- key_match = key_loaded && (cmd_key == cur_key).
- RUN:
  - cmd_ready = cmd_valid && key_match && (inflight < MAX_INFLIGHT); combinational, no registered-ready bubble.
  - On handshake, register the issue strobe selected by cmd_op for one cycle, with cmd_data on plain_text (enc) or cipher_text_in (dec); the other data output holds its value.
  - If cmd_valid && !key_match: cmd_ready = 0, go to DRAIN. The pending command is not consumed.
- DRAIN:
  - cmd_ready = 0.
  - When inflight == 0 and no issue strobe is pending, go to LOAD and capture cur_key <= cmd_key.
- LOAD:
  - load_new_key = 1 for exactly this cycle; cipher_key = cur_key (already updated).
  - key_loaded <= 0. Go to WAIT_KEY with timer = 0.
- WAIT_KEY:
  - When key_is_valid == 1, set key_loaded <= 1 and go to RUN.
  - Else timer increments. At timer == KEY_TIMEOUT-1 with key_is_valid still 0, set key_err and go to ERROR.
- ERROR:
  - cmd_ready = 0.
  - clear_err clears key_err and returns to RUN with key_loaded = 0, so the next command retries the load.
- Counter:
  - inflight_next = inflight + issue_hs − enc_out_valid − dec_out_valid; a simultaneous increment and double decrement is legal.
  - If a decrement would go below 0, clamp at 0 and set cnt_err.
  - clear_err also clears cnt_err.
- key_flush:
  - Clears key_loaded in any state; the current RUN handshake in the same cycle still completes.
  - In WAIT_KEY, key_flush has no effect on key_loaded; the fresh load wins.
- cmd_valid dropping during DRAIN is legal. When the pipelines are empty, go to LOAD only if cmd_valid is still high; otherwise return to RUN.

## Timing
- Issue latency: handshake at cycle t produces enc_in_valid or dec_in_valid at t+1.
- Throughput: one job per cycle in RUN.
- key_is_valid from the core updates the cycle after load_new_key, so it is never sampled in the LOAD cycle.
- Key switch cost, from the mismatch cycle:
  - drain time, plus 1 LOAD cycle, plus the expansion time, plus 1 cycle;
  - the first new-key handshake occurs in the RUN cycle after key_is_valid is seen.
- Asynchronous reset mid-operation drops all in-flight accounting. The integrator must reset the core on the same rst_n.

## Test plan
- Cold start:
  - Stimulus: after reset, cmd_valid, op = 0, key = K1, data = 0x00112233…eeff.
  - Required: exactly one load_new_key pulse carrying K1; model key_is_valid rising 10 cycles later; enc_in_valid 2 cycles after it rises, carrying the data.
- Streaming:
  - Stimulus: 40 back-to-back jobs with K1 and a core modelled with 11-cycle latency.
  - Required: cmd_ready stalls when inflight = 32; inflight peaks at 32; returns to 0; no cnt_err.
- Key switch:
  - Stimulus: jobs with K1 ×5, then K2.
  - Required: K2 stalls until inflight = 0; load_new_key fires with cipher_key = K2 and no issue strobe during DRAIN, LOAD or WAIT_KEY.
- Mixed enc/dec:
  - Stimulus: alternating ops with simultaneous enc_out_valid and dec_out_valid.
  - Required: inflight decrements by 2 in that cycle.
- Timeout:
  - Stimulus: key_is_valid held at 0.
  - Required: key_err set after 64 WAIT_KEY cycles; cmd_ready = 0 until clear_err; then a fresh load pulse.
- Underflow and flush:
  - Stimulus: a spurious dec_out_valid with inflight = 0.
  - Required: cnt_err = 1 and inflight stays 0.
  - Stimulus: key_flush, then a same-key job.
  - Required: the job triggers a reload.
